// File: rtl/norm_count_seq_pkg.sv
// rtl/norm_count_seq_pkg.sv - shared constants, types and helpers for the normalizer
package norm_count_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 6;
  localparam int N_STEPS = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [0:DATA_W-1] word_t;
  typedef logic [0:CNT_W-1]  cnt_t;

  // Binary search widths 16,8,4,2,1 for steps 0..4
  function automatic int step_width(input int k);
    return 16 >> k;
  endfunction

  // A bit is set where it differs from its right neighbour; bit 31 is a sentinel,
  // so arithmetic results never exceed 31
  function automatic word_t sign_search(input word_t a);
    return (a ^ (a << 1)) | word_t'(1);
  endfunction

endpackage

// File: rtl/norm_count_seq_if.sv
// rtl/norm_count_seq_if.sv - operand/result handshake bundle for norm_count_seq
interface norm_count_seq_if;
  import norm_count_seq_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t a;
  logic  arith;
  logic  out_valid;
  logic  out_ready;
  cnt_t  count;
  word_t norm;
  logic  zero;

  modport master (
    output in_valid, a, arith, out_ready,
    input  in_ready, out_valid, count, norm, zero
  );

  modport slave (
    input  in_valid, a, arith, out_ready,
    output in_ready, out_valid, count, norm, zero
  );

endinterface

// File: rtl/norm_count_seq_norm_step.sv
// rtl/norm_count_seq_norm_step.sv - one binary-search step: test top W bits, shift if clear
module norm_step
  import norm_count_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  word_t t_i,
  input  word_t norm_i,
  output word_t t_o,
  output word_t norm_o,
  output logic  hit_o
);

  assign hit_o  = (t_i[0:W-1] == '0);
  assign t_o    = t_i << W;
  assign norm_o = norm_i << W;

endmodule

// File: rtl/norm_count_seq.sv
// rtl/norm_count_seq.sv - iterative CLZ/CLS normalizer with valid/ready handshake
module norm_count_seq
  import norm_count_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  norm_count_seq_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  word_t      t_q, t_d;
  word_t      norm_q, norm_d;
  cnt_t       count_q, count_d;
  logic       zero_q, zero_d;
  logic       lz_q, lz_d;

  word_t              t_s    [N_STEPS];
  word_t              norm_s [N_STEPS];
  logic [N_STEPS-1:0] hit_s;

  logic  sel_hit;
  word_t sel_t;
  word_t sel_norm;
  cnt_t  sel_w;

  for (genvar k = 0; k < N_STEPS; k++) begin : g_step
    norm_step #(.W(step_width(k))) u_step (
      .t_i    (t_q),
      .norm_i (norm_q),
      .t_o    (t_s[k]),
      .norm_o (norm_s[k]),
      .hit_o  (hit_s[k])
    );
  end

  always_comb begin
    sel_hit  = 1'b0;
    sel_t    = t_q;
    sel_norm = norm_q;
    sel_w    = '0;
    for (int k = 0; k < N_STEPS; k++) begin
      if (step_q == 3'(k)) begin
        sel_hit  = hit_s[k];
        sel_t    = t_s[k];
        sel_norm = norm_s[k];
        sel_w    = cnt_t'(step_width(k));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    t_d     = t_q;
    norm_d  = norm_q;
    count_d = count_q;
    zero_d  = zero_q;
    lz_d    = lz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          t_d     = bus.arith ? sign_search(bus.a) : bus.a;
          norm_d  = bus.a;
          count_d = '0;
          zero_d  = 1'b0;
          lz_d    = !bus.arith && (bus.a == '0);
          step_d  = 3'd0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (sel_hit) begin
          t_d     = sel_t;
          norm_d  = sel_norm;
          count_d = count_q + sel_w;
        end
        if (step_q == 3'(N_STEPS - 1)) begin
          state_d = ST_DONE;
          // An all-zero logical operand would stop at 31; report the full width
          if (lz_q) begin
            count_d = cnt_t'(DATA_W);
            norm_d  = '0;
            zero_d  = 1'b1;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      t_q     <= '0;
      norm_q  <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      lz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      t_q     <= t_d;
      norm_q  <= norm_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      lz_q    <= lz_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.count     = count_q;
  assign bus.norm      = norm_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_norm_count_seq.sv
// tb/tb_norm_count_seq.sv - self-checking bench for norm_count_seq
module tb_norm_count_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  norm_count_seq_if bus ();

  norm_count_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic        arith;
    logic [5:0]  cnt;
    logic [31:0] nrm;
    logic        z;
  } vec_t;

  typedef struct {
    logic [5:0]  cnt;
    logic [31:0] nrm;
    logic        z;
    int          acc;
  } sb_t;

  sb_t  sb_q[$];
  logic ov_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic void model(input logic [31:0] a, input logic arith,
                                output logic [5:0] c, output logic [31:0] n, output logic z);
    int k;
    k = 0;
    if (!arith) begin
      while (k < 32 && a[31-k] == 1'b0) k++;
      z = (a == 32'h0);
    end else begin
      while (k < 31 && a[30-k] == a[31]) k++;
      z = 1'b0;
    end
    c = 6'(k);
    n = (k >= 32) ? 32'h0 : (a << k);
  endfunction

  // Scoreboard consumer and latency monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev && sb_q.size() > 0)
        chk("latency", 64'(cyc - sb_q[0].acc), 64'd5);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'(bus.out_valid), 64'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("count", 64'(bus.count), 64'(e.cnt));
          chk("norm",  64'(bus.norm),  64'(e.nrm));
          chk("zero",  64'(bus.zero),  64'(e.z));
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic arith,
                       input logic [5:0] ec, input logic [31:0] en, input logic ez);
    int  n;
    sb_t e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.arith    = arith;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      fail_now("accept_timeout");
    end else begin
      e.cnt = ec; e.nrm = en; e.z = ez; e.acc = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now(name);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] ra;
    logic        rm;
    logic [5:0]  rc;
    logic [31:0] rn;
    logic        rz;
    int          sh;
    int          n;

    vecs[0] = '{32'h00010000, 1'b0, 6'd15, 32'h80000000, 1'b0};
    vecs[1] = '{32'h00000000, 1'b0, 6'd32, 32'h00000000, 1'b1};
    vecs[2] = '{32'h80000000, 1'b0, 6'd0,  32'h80000000, 1'b0};
    vecs[3] = '{32'hFFFF8000, 1'b1, 6'd16, 32'h80000000, 1'b0};
    vecs[4] = '{32'h00000001, 1'b1, 6'd30, 32'h40000000, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 1'b1, 6'd31, 32'h80000000, 1'b0};
    vecs[6] = '{32'h00000000, 1'b1, 6'd31, 32'h00000000, 1'b0};
    vecs[7] = '{32'h00000001, 1'b0, 6'd31, 32'h80000000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.arith     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_norm",      64'(bus.norm),      64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].arith, vecs[i].cnt, vecs[i].nrm, vecs[i].z);
      drain("vec_drain");
    end

    // Back-pressure: results frozen in DONE, new operand ignored
    bus.out_ready = 1'b0;
    issue(32'h00F00000, 1'b0, 6'd8, 32'hF0000000, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now("hold_wait");
    bus.in_valid = 1'b1;
    bus.a        = 32'hFFFFFFFF;
    bus.arith    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready",  64'(bus.in_ready),  64'd0);
      chk("hold_result", 64'({bus.count, bus.norm, bus.zero}), 64'({6'd8, 32'hF0000000, 1'b0}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("hold_drain");
    chk("hold_idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of CALC at step 2
    issue(32'h00010000, 1'b0, 6'd15, 32'h80000000, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result", 64'({bus.count, bus.norm, bus.zero}), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_result", 64'(bus.out_valid), 64'd0);
    issue(32'h00000F00, 1'b0, 6'd20, 32'hF0000000, 1'b0);
    drain("post_rst_drain");

    // Random back-to-back sweep against the reference model
    for (int i = 0; i < 5000; i++) begin
      ra = $urandom;
      sh = $urandom_range(0, 33);
      ra = (sh < 32) ? (ra >> sh) : 32'h0;
      rm = 1'($urandom_range(0, 1));
      if (rm && $urandom_range(0, 1) == 1) ra = ~ra;
      model(ra, rm, rc, rn, rz);
      issue(ra, rm, rc, rn, rz);
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
